key_check_debounce: RTL and testbench

- Four-channel push-button conditioner for the directional keys (Left/Right/Up/Down) of the game controller.
- Each raw input is synchronised to the 50 MHz clock and debounced by a stable-time counter.
- Each channel emits a single-cycle press pulse on its Key_* output, consumed by the direction/control logic downstream.

---
 rtl/key_check_pkg.sv | 19 +
 rtl/key_debounce_ch.sv | 51 +++++
 rtl/key_check_debounce.sv | 44 ++++
 tb/tb_key_check_debounce.sv | 137 +++++++++++++
 4 files changed

// File: rtl/key_check_pkg.sv
// Shared constants, counter-width helper and key index names for the directional key conditioner.
package key_check_pkg;

    localparam int DEBOUNCE_DEFAULT = 1000;
    localparam int DEBOUNCE_BOARD   = 1_000_000;
    localparam int NUM_KEYS         = 4;

    typedef enum logic [1:0] {
        KEY_LEFT  = 2'd0,
        KEY_RIGHT = 2'd1,
        KEY_UP    = 2'd2,
        KEY_DOWN  = 2'd3
    } key_idx_e;

    function automatic int cnt_width(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: two-flop synchroniser, stable-time counter and registered output.
// KEY_CHECK_LEVEL_OUT_EN selects the debounced level on key instead of a press pulse.
module key_debounce_ch
    import key_check_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic key
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1, s2, stable;
    logic [CNT_W-1:0] cnt;
    logic             differ, done;

    assign differ = (s2 != stable);
    assign done   = differ && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
            key    <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            // Any return to the stable level restarts qualification.
            if (!differ) begin
                cnt <= '0;
            end else if (done) begin
                stable <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
`ifdef KEY_CHECK_LEVEL_OUT_EN
            key <= done ? s2 : stable;
`else
            key <= done & s2;
`endif
        end
    end

endmodule

// File: rtl/key_check_debounce.sv
// Four-channel directional key conditioner; each channel is an independent key_debounce_ch.
// KEY_CHECK_LEVEL_OUT_EN (in the channel) switches outputs from press pulses to debounced levels.
module key_check_debounce
    import key_check_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic Clk_50mhz,
    input  logic Rst_n,
    input  logic Left,
    input  logic Right,
    input  logic Up,
    input  logic Down,
    output logic Key_left,
    output logic Key_right,
    output logic Key_up,
    output logic Key_down
);

    logic [NUM_KEYS-1:0] raw;
    logic [NUM_KEYS-1:0] key;

    assign raw[int'(KEY_LEFT)]  = Left;
    assign raw[int'(KEY_RIGHT)] = Right;
    assign raw[int'(KEY_UP)]    = Up;
    assign raw[int'(KEY_DOWN)]  = Down;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk   (Clk_50mhz),
            .rst_n (Rst_n),
            .raw   (raw[i]),
            .key   (key[i])
        );
    end

    assign Key_left  = key[int'(KEY_LEFT)];
    assign Key_right = key[int'(KEY_RIGHT)];
    assign Key_up    = key[int'(KEY_UP)];
    assign Key_down  = key[int'(KEY_DOWN)];

endmodule

// File: tb/tb_key_check_debounce.sv
// Scoreboard bench for key_check_debounce in pulse mode: expected pulses are queued when keys are driven.
module tb_key_check_debounce;

    localparam int D = 1000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic left = 1'b0, right = 1'b0, up = 1'b0, down = 1'b0;
    logic key_left, key_right, key_up, key_down;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        int         cyc;
        logic [3:0] keys;
    } exp_t;

    exp_t sb[$];

    key_check_debounce #(.DEBOUNCE_CYCLES(D)) dut (
        .Clk_50mhz (clk),
        .Rst_n     (rst_n),
        .Left      (left),
        .Right     (right),
        .Up        (up),
        .Down      (down),
        .Key_left  (key_left),
        .Key_right (key_right),
        .Key_up    (key_up),
        .Key_down  (key_down)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [3:0] keys_now();
        return {key_down, key_up, key_right, key_left};
    endfunction

    // Inputs change at a negedge while cyc==c; capture edge is c+1, pulse seen at negedge c+D+2.
    task automatic push(input int c, input logic [3:0] k);
        exp_t e;
        e.cyc  = c + D + 2;
        e.keys = k;
        sb.push_back(e);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (keys_now() != 4'b0) begin
            if (sb.size() == 0) begin
                chk("spurious", int'(keys_now()), 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pulse_cyc", cyc, e.cyc);
                chk("pulse_keys", int'(keys_now()), int'(e.keys));
            end
        end
    end

    initial begin
        // Reset with all keys low
        wait_clk(5);
        chk("rst_out", int'(keys_now()), 0);
        rst_n = 1'b1;
        wait_clk(100);
        chk("post_rst_out", int'(keys_now()), 0);
        chk("post_rst_cnt", int'(dut.g_ch[0].u_ch.cnt), 0);

        // Clean press on Left, no pulse on release
        left = 1'b1; push(cyc, 4'b0001);
        wait_clk(5000);
        left = 1'b0;
        wait_clk(1200);
        chk("left_pending", sb.size(), 0);

        // Sequential Right, Up, Down: 5000-clock presses with 100-clock gaps
        right = 1'b1; push(cyc, 4'b0010);
        wait_clk(5000); right = 1'b0; wait_clk(100);
        up = 1'b1; push(cyc, 4'b0100);
        wait_clk(5000); up = 1'b0; wait_clk(100);
        down = 1'b1; push(cyc, 4'b1000);
        wait_clk(5000); down = 1'b0;
        wait_clk(1200);
        chk("seq_pending", sb.size(), 0);

        // Bounce on Up: 200-clock toggles, then a firm hold
        for (int i = 0; i < 10; i++) begin
            up = (i % 2 == 0);
            wait_clk(200);
        end
        up = 1'b1; push(cyc, 4'b0100);
        wait_clk(2000);
        up = 1'b0;
        wait_clk(1200);
        chk("bounce_pending", sb.size(), 0);

        // Simultaneous Left and Down
        left = 1'b1; down = 1'b1; push(cyc, 4'b1001);
        wait_clk(3000);
        left = 1'b0; down = 1'b0;
        wait_clk(1200);
        chk("simul_pending", sb.size(), 0);

        // Same again, reset for one clock mid-count; held keys re-qualify after release
        left = 1'b1; down = 1'b1;
        wait_clk(500);
        rst_n = 1'b0;
        wait_clk(1);
        chk("midrst_out", int'(keys_now()), 0);
        rst_n = 1'b1;
        // first capture after reset is the edge following this negedge
        push(cyc, 4'b1001);
        wait_clk(3000);
        left = 1'b0; down = 1'b0;
        wait_clk(1200);
        chk("midrst_pending", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
